// File: rtl/ring_heater_lock_ctrl.sv
// Thermal lock controller for a ring modulator heater: coarse sweep to the
// thru-port power minimum, then 3-point dither tracking, plus a first-order PDM drive.
module ring_heater_lock_ctrl #(
    parameter int BIT_WIDTH     = 8,
    parameter int PD_W          = 10,
    parameter int SETTLE_CYCLES = 16,
    parameter int INIT_CODE     = 128,
    parameter int RELOCK_THRESH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 pd_valid,
    input  logic [PD_W-1:0]      pd_sample,
    output logic [BIT_WIDTH-1:0] heater_code,
    output logic                 pdm_out,
    output logic                 busy,
    output logic                 locked,
    output logic                 lock_lost
);

    localparam int                   CNT_W     = $clog2(SETTLE_CYCLES + 1);
    localparam logic [BIT_WIDTH-1:0] CODE_MAX  = '1;
    localparam logic [BIT_WIDTH-1:0] CODE_ZERO = '0;
    localparam logic [BIT_WIDTH-1:0] CODE_ONE  = BIT_WIDTH'(1);
    localparam logic [BIT_WIDTH-1:0] CODE_INIT = BIT_WIDTH'(INIT_CODE);
    localparam logic [PD_W-1:0]      PWR_ONES  = '1;
    localparam logic [CNT_W-1:0]     SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
    localparam logic [PD_W:0]        THRESH    = (PD_W+1)'(RELOCK_THRESH);

    typedef enum logic [2:0] {
        IDLE,
        SW_SAMPLE,
        GO_BEST,
        TR_C,
        TR_UP,
        TR_DN
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     settle_cnt;
    logic [BIT_WIDTH-1:0] code_seen;
    logic [PD_W-1:0]      best_pwr;
    logic [BIT_WIDTH-1:0] best_code;
    logic [BIT_WIDTH-1:0] center_code;
    logic [PD_W-1:0]      center_pwr;
    logic [PD_W-1:0]      up_pwr;
    logic [BIT_WIDTH-1:0] pdm_acc;

    logic                 sample_ok;
    logic                 lost_hit;
    logic                 sweep_better;
    logic [PD_W-1:0]      up_eff;
    logic [PD_W-1:0]      dn_eff;
    logic [BIT_WIDTH-1:0] pick_code;
    logic [PD_W-1:0]      pick_pwr;

    // A code change is seen one cycle late through code_seen, so the load
    // value is one short; the first acceptable sample still lands SETTLE_CYCLES+1 edges later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
            code_seen  <= CODE_INIT;
        end else if (heater_code != code_seen) begin
            code_seen  <= heater_code;
            settle_cnt <= SETTLE_LD;
        end else if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - CNT_ONE;
        end
    end

    assign sample_ok    = pd_valid && (settle_cnt == '0) && (heater_code == code_seen);
    assign lost_hit     = {1'b0, pd_sample} > ({1'b0, best_pwr} + THRESH);
    assign sweep_better = pd_sample < best_pwr;
    assign up_eff       = (state == TR_UP) ? pd_sample : up_pwr;
    assign dn_eff       = (state == TR_DN) ? pd_sample : PWR_ONES;

    // Skipped probes read as all-ones, so they can never beat a real sample.
    always_comb begin
        pick_code = center_code;
        pick_pwr  = center_pwr;
        if (!((center_pwr <= dn_eff) && (center_pwr <= up_eff))) begin
            if (dn_eff <= up_eff) begin
                pick_code = center_code - CODE_ONE;
                pick_pwr  = dn_eff;
            end else begin
                pick_code = center_code + CODE_ONE;
                pick_pwr  = up_eff;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            heater_code <= CODE_INIT;
            busy        <= 1'b0;
            locked      <= 1'b0;
            lock_lost   <= 1'b0;
            best_pwr    <= PWR_ONES;
            best_code   <= CODE_ZERO;
            center_code <= CODE_ZERO;
            center_pwr  <= PWR_ONES;
            up_pwr      <= PWR_ONES;
        end else begin
            lock_lost <= 1'b0;
            if (stop) begin
                state       <= IDLE;
                heater_code <= CODE_INIT;
                busy        <= 1'b0;
                locked      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state       <= SW_SAMPLE;
                            heater_code <= CODE_ZERO;
                            best_pwr    <= PWR_ONES;
                            best_code   <= CODE_ZERO;
                            busy        <= 1'b1;
                            locked      <= 1'b0;
                        end
                    end
                    SW_SAMPLE: begin
                        if (sample_ok) begin
                            if (sweep_better) begin
                                best_pwr  <= pd_sample;
                                best_code <= heater_code;
                            end
                            if (heater_code == CODE_MAX) begin
                                state       <= GO_BEST;
                                heater_code <= sweep_better ? heater_code : best_code;
                            end else begin
                                heater_code <= heater_code + CODE_ONE;
                            end
                        end
                    end
                    GO_BEST: begin
                        if (sample_ok) begin
                            best_pwr <= pd_sample;
                            state    <= TR_C;
                            locked   <= 1'b1;
                        end
                    end
                    TR_C: begin
                        if (sample_ok) begin
                            if (lost_hit) begin
                                lock_lost   <= 1'b1;
                                locked      <= 1'b0;
                                state       <= SW_SAMPLE;
                                heater_code <= CODE_ZERO;
                                best_pwr    <= PWR_ONES;
                                best_code   <= CODE_ZERO;
                            end else begin
                                center_pwr  <= pd_sample;
                                center_code <= heater_code;
                                if (heater_code != CODE_MAX) begin
                                    heater_code <= heater_code + CODE_ONE;
                                    state       <= TR_UP;
                                end else begin
                                    up_pwr      <= PWR_ONES;
                                    heater_code <= heater_code - CODE_ONE;
                                    state       <= TR_DN;
                                end
                            end
                        end
                    end
                    TR_UP: begin
                        if (sample_ok) begin
                            up_pwr <= pd_sample;
                            if (center_code != CODE_ZERO) begin
                                heater_code <= center_code - CODE_ONE;
                                state       <= TR_DN;
                            end else begin
                                heater_code <= pick_code;
                                best_pwr    <= pick_pwr;
                                state       <= TR_C;
                            end
                        end
                    end
                    TR_DN: begin
                        if (sample_ok) begin
                            heater_code <= pick_code;
                            best_pwr    <= pick_pwr;
                            state       <= TR_C;
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        heater_code <= CODE_INIT;
                        busy        <= 1'b0;
                        locked      <= 1'b0;
                    end
                endcase
            end
        end
    end

    // First-order sigma-delta: the carry out of the accumulator is the drive bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pdm_acc <= '0;
            pdm_out <= 1'b0;
        end else begin
            {pdm_out, pdm_acc} <= {1'b0, pdm_acc} + {1'b0, heater_code};
        end
    end

endmodule

// File: tb/tb_ring_heater_lock_ctrl.sv
// Bench for ring_heater_lock_ctrl: closed-loop plant on a small 4-bit instance checked
// against a sweep/dither reference, plus reset, stop and PDM checks on 8-bit instances.
module tb_ring_heater_lock_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small instance: 4-bit codes, short settle
    logic       rst_s = 1'b1, start_s = 1'b0, stop_s = 1'b0, valid_s = 1'b0;
    logic [9:0] sample_s = '0;
    logic [3:0] code_s;
    logic       pdm_s, busy_s, locked_s, lost_s;

    // Wide instance: default parameters
    logic       rst_w = 1'b1, start_w = 1'b0, stop_w = 1'b0, valid_w = 1'b0;
    logic [9:0] sample_w = '0;
    logic [7:0] code_w;
    logic       pdm_w, busy_w, locked_w, lost_w;

    // PDM instance idling at code 64
    logic [7:0] code_p;
    logic       pdm_p, busy_p, locked_p, lost_p;

    ring_heater_lock_ctrl #(.BIT_WIDTH(4), .PD_W(10), .SETTLE_CYCLES(2),
                            .INIT_CODE(8), .RELOCK_THRESH(32)) dut_s (
        .clk(clk), .rst(rst_s), .start(start_s), .stop(stop_s),
        .pd_valid(valid_s), .pd_sample(sample_s), .heater_code(code_s),
        .pdm_out(pdm_s), .busy(busy_s), .locked(locked_s), .lock_lost(lost_s));

    ring_heater_lock_ctrl dut_w (
        .clk(clk), .rst(rst_w), .start(start_w), .stop(stop_w),
        .pd_valid(valid_w), .pd_sample(sample_w), .heater_code(code_w),
        .pdm_out(pdm_w), .busy(busy_w), .locked(locked_w), .lock_lost(lost_w));

    ring_heater_lock_ctrl #(.INIT_CODE(64)) dut_p (
        .clk(clk), .rst(rst_s), .start(1'b0), .stop(1'b0),
        .pd_valid(1'b0), .pd_sample(10'd0), .heater_code(code_p),
        .pdm_out(pdm_p), .busy(busy_p), .locked(locked_p), .lock_lost(lost_p));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Plant: phases keyed by how many code changes have happened so far
    int ph_start[8] = '{0, 60, 90, 120, 170, 230, 290, 350};
    int ph_tgt[8]   = '{9, 10, 11, 3, -1, 15, 0, 5};
    localparam int N_EV = 420;

    function automatic int plant(input int code, input int nchg);
        int p = 0;
        int d;
        for (int i = 0; i < 8; i++) if (nchg >= ph_start[i]) p = i;
        if (ph_tgt[p] < 0) return 100;
        d = code - ph_tgt[p];
        if (d < 0) d = -d;
        return d * 20;
    endfunction

    // Reference: expected sequence of distinct heater codes with lock flag, and lock-loss points
    int exp_code[$];
    int exp_lock[$];
    int exp_lost_at[$];
    int m_cur, m_cnt;

    task automatic mvisit(input int c, input int lk);
        if (c != m_cur) begin
            exp_code.push_back(c);
            exp_lock.push_back(lk);
            m_cnt++;
            m_cur = c;
        end
    endtask

    task automatic build_model();
        int best, bc, s, center, sc, up, dn, nc;
        bit sweeping;
        m_cur = 8; m_cnt = 0; sweeping = 1'b1; best = 1023;
        while (m_cnt < N_EV) begin
            if (sweeping) begin
                best = 1023; bc = 0;
                for (int c = 0; c < 16; c++) begin
                    mvisit(c, 0);
                    s = plant(c, m_cnt);
                    if (s < best) begin best = s; bc = c; end
                end
                mvisit(bc, 0);
                best = plant(bc, m_cnt);
                sweeping = 1'b0;
            end else begin
                center = m_cur;
                sc = plant(center, m_cnt);
                if (sc > best + 32) begin
                    mvisit(0, 0);
                    exp_lost_at.push_back(m_cnt);
                    sweeping = 1'b1;
                end else begin
                    up = 1023; dn = 1023;
                    if (center < 15) begin mvisit(center + 1, 1); up = plant(center + 1, m_cnt); end
                    if (center > 0)  begin mvisit(center - 1, 1); dn = plant(center - 1, m_cnt); end
                    if (sc <= up && sc <= dn) begin nc = center;     best = sc; end
                    else if (dn <= up)        begin nc = center - 1; best = dn; end
                    else                      begin nc = center + 1; best = up; end
                    mvisit(nc, 1);
                end
            end
        end
    endtask

    // Monitor and plant driver for the small instance
    int         ev_i = 0;
    int         li = 0;
    int         gap_s = 0;
    logic [3:0] prev_code_s = 4'd8;
    logic       prev_lost = 1'b0;
    bit         mon_on = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            gap_s++;
            if (mon_on) begin
                if (code_s != prev_code_s) begin
                    if (ev_i < exp_code.size()) begin
                        check("code", int'(code_s), exp_code[ev_i]);
                        check("locked", int'(locked_s), exp_lock[ev_i]);
                        check("busy", int'(busy_s), 1);
                        if (ev_i > 0) check("settle", int'(gap_s >= 3 && valid_s), 1);
                    end
                    ev_i++;
                    gap_s = 0;
                end
                if (lost_s) begin
                    if (li < exp_lost_at.size()) check("lost_at", ev_i, exp_lost_at[li]);
                    else check("lost_extra", li, exp_lost_at.size());
                    check("lost_width", int'(prev_lost), 0);
                    li++;
                end
            end
            prev_code_s = code_s;
            prev_lost   = lost_s;
            sample_s = 10'(plant(int'(code_s), ev_i));
            valid_s  = ($urandom_range(0, 9) < 7);
            valid_w  = $urandom_range(0, 1) == 1;
            sample_w = 10'($urandom_range(0, 1023));
        end
    end

    initial begin
        int ones_w, ones_p, ones_s;
        int k;
        ph_tgt[7] = $urandom_range(1, 14);

        repeat (3) @(negedge clk);
        check("rst_code_w", int'(code_w), 128);
        check("rst_busy_w", int'(busy_w), 0);
        check("rst_locked_w", int'(locked_w), 0);
        check("rst_lost_w", int'(lost_w), 0);
        check("rst_pdm_w", int'(pdm_w), 0);
        check("rst_code_s", int'(code_s), 8);
        check("rst_code_p", int'(code_p), 64);
        rst_s = 1'b0;
        rst_w = 1'b0;

        ones_w = 0; ones_p = 0; ones_s = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            ones_w += int'(pdm_w);
            ones_p += int'(pdm_p);
            ones_s += int'(pdm_s);
        end
        check("pdm_ones_128", ones_w, 128);
        check("pdm_ones_64", ones_p, 64);
        check("pdm_ones_8of16", ones_s, 128);

        start_w = 1'b1; stop_w = 1'b1;
        repeat (3) @(negedge clk);
        check("stop_prio_busy", int'(busy_w), 0);
        check("stop_prio_code", int'(code_w), 128);
        stop_w = 1'b0;
        @(negedge clk);
        check("start_busy", int'(busy_w), 1);
        check("start_code", int'(code_w), 0);
        check("start_locked", int'(locked_w), 0);
        start_w = 1'b0;

        for (k = 0; k < 8000 && code_w != 8'd57; k++) @(negedge clk);
        check("reach_57", int'(code_w), 57);
        rst_w = 1'b1;
        #1;
        check("midrst_code", int'(code_w), 128);
        check("midrst_busy", int'(busy_w), 0);
        check("midrst_locked", int'(locked_w), 0);
        check("midrst_pdm", int'(pdm_w), 0);
        @(negedge clk);
        rst_w = 1'b0;

        start_w = 1'b1;
        @(negedge clk);
        start_w = 1'b0;
        for (k = 0; k < 4000 && code_w != 8'd20; k++) @(negedge clk);
        check("reach_20", int'(code_w), 20);
        stop_w = 1'b1;
        @(negedge clk);
        check("stop_code", int'(code_w), 128);
        check("stop_busy", int'(busy_w), 0);
        check("stop_locked", int'(locked_w), 0);
        stop_w = 1'b0;

        build_model();
        mon_on  = 1'b1;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        for (k = 0; k < 30000 && ev_i < exp_code.size(); k++) @(negedge clk);
        check("events_done", ev_i, exp_code.size());
        check("lost_count", li, exp_lost_at.size());
        mon_on = 1'b0;
        @(negedge clk);
        stop_s = 1'b1;
        @(negedge clk);
        check("stop_code_s", int'(code_s), 8);
        check("stop_busy_s", int'(busy_s), 0);
        check("stop_locked_s", int'(locked_s), 0);
        stop_s = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
